// File: rtl/dmem_responder_if.sv
// dmem_responder_if: core data-memory bus between the core (master) and the
// memory responder (slave).
//   dmaddr_in    [31:0] byte address, address phase
//   dmwr_req_in         1 = write, 0 = read, address phase
//   dmwr_mask_in [3:0]  byte-lane write enables, address phase
//   dmdata_in    [31:0] write data, data phase
//   htrans_in    [1:0]  IDLE/BUSY/NONSEQ/SEQ
//   data_out     [31:0] read data
//   hready_out          data phase completes / address phase accepted
//   hresp_out           1 = ERROR response
interface dmem_responder_if;
  logic [31:0] dmaddr_in;
  logic        dmwr_req_in;
  logic [3:0]  dmwr_mask_in;
  logic [31:0] dmdata_in;
  logic [1:0]  htrans_in;
  logic [31:0] data_out;
  logic        hready_out;
  logic        hresp_out;

  modport master (
    output dmaddr_in, dmwr_req_in, dmwr_mask_in, dmdata_in, htrans_in,
    input  data_out, hready_out, hresp_out
  );

  modport slave (
    input  dmaddr_in, dmwr_req_in, dmwr_mask_in, dmdata_in, htrans_in,
    output data_out, hready_out, hresp_out
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: single-port data memory behind an AHB-like pipelined bus.
// Address phase is accepted when hready_out=1 and htrans is NONSEQ/SEQ. Valid
// transfers insert WAIT_STATES hready-low cycles; out-of-range addresses get a
// two-cycle ERROR response. Reads sample memory at the accept edge (with
// forwarding from a write committing on that same edge); writes commit at the
// completing data-phase edge.
//   msriscv32_mp_clk_in  clock, rising edge
//   msriscv32_mp_rst_in  synchronous active-high reset
//   bus                  dmem_responder_if slave modport
module dmem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 1
) (
  input  logic              msriscv32_mp_clk_in,
  input  logic              msriscv32_mp_rst_in,
  dmem_responder_if.slave   bus
);
  localparam int          IDX_W   = $clog2(DEPTH_WORDS);
  localparam logic [32:0] LO_ADDR = {1'b0, BASE_ADDR};
  localparam logic [32:0] HI_ADDR = LO_ADDR + 33'(DEPTH_WORDS) * 33'd4 - 33'd1;
  localparam logic [3:0]  WS      = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_ERR1, S_ERR2} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q;
  logic              wr_q;
  logic [3:0]        mask_q;
  logic [31:0]       rdata_q;
  logic              hready_q, hresp_q;
  logic [31:0]       mem [DEPTH_WORDS];

  logic              accept, addr_ok, commit;
  logic [32:0]       addr33;
  logic [31:0]       offs;
  logic [IDX_W-1:0]  nidx;
  logic [31:0]       rd_word;

  assign accept = hready_q & bus.htrans_in[1];
  // 33-bit unsigned compare so BASE_ADDR near the top of the space cannot wrap
  assign addr33  = {1'b0, bus.dmaddr_in};
  assign addr_ok = (addr33 >= LO_ADDR) && (addr33 <= HI_ADDR);
  assign offs    = bus.dmaddr_in - BASE_ADDR;
  assign nidx    = IDX_W'(offs >> 2);
  assign commit  = (state_q == S_DATA) && (cnt_q == 4'd0) && wr_q;

  // Read word for an accept on this edge; a write committing on the same edge
  // to the same word is merged in so the read sees the new bytes.
  always_comb begin
    rd_word = mem[nidx];
    if (commit && (nidx == idx_q)) begin
      for (int b = 0; b < 4; b++)
        if (mask_q[b]) rd_word[8*b +: 8] = bus.dmdata_in[8*b +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (hready_q) begin
      // IDLE, completing DATA or ERR2: either pipeline the next address phase
      // in without a bubble, or fall back to IDLE
      if (accept) begin
        state_d = addr_ok ? S_DATA : S_ERR1;
        cnt_d   = addr_ok ? WS : 4'd0;
      end else begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    end else begin
      case (state_q)
        S_DATA:  cnt_d   = cnt_q - 4'd1;
        S_ERR1:  state_d = S_ERR2;
        default: ;
      endcase
    end
  end

  always_ff @(posedge msriscv32_mp_clk_in) begin
    if (msriscv32_mp_rst_in) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      rdata_q  <= 32'h0;
      hready_q <= 1'b1;
      hresp_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hready_q <= (state_d == S_IDLE) || (state_d == S_ERR2) ||
                  ((state_d == S_DATA) && (cnt_d == 4'd0));
      hresp_q  <= (state_d == S_ERR1) || (state_d == S_ERR2);
      if (accept) begin
        idx_q  <= nidx;
        wr_q   <= bus.dmwr_req_in;
        mask_q <= bus.dmwr_mask_in;
        if (addr_ok && !bus.dmwr_req_in) rdata_q <= rd_word;
      end
    end
  end

  // Storage is never reset; a reset edge also drops any pending write.
  always_ff @(posedge msriscv32_mp_clk_in) begin
    if (!msriscv32_mp_rst_in && commit) begin
      for (int b = 0; b < 4; b++)
        if (mask_q[b]) mem[idx_q][8*b +: 8] <= bus.dmdata_in[8*b +: 8];
    end
  end

  assign bus.data_out   = rdata_q;
  assign bus.hready_out = hready_q;
  assign bus.hresp_out  = hresp_q;
endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_responder_if bus0 ();
  dmem_responder_if bus1 ();

  dmem_responder #(.BASE_ADDR(32'h0), .DEPTH_WORDS(1024), .WAIT_STATES(1)) dut0 (
    .msriscv32_mp_clk_in(clk), .msriscv32_mp_rst_in(rst), .bus(bus0));
  dmem_responder #(.BASE_ADDR(32'h0), .DEPTH_WORDS(1024), .WAIT_STATES(0)) dut1 (
    .msriscv32_mp_clk_in(clk), .msriscv32_mp_rst_in(rst), .bus(bus1));

  int checks = 0;
  int errors = 0;
  logic [31:0] sb [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Drive an address phase on dut0 at the current negedge; returns at the
  // negedge just after the accept edge.
  task automatic accept0(input string tag, input logic [31:0] addr, input logic wr,
                         input logic [3:0] mask);
    chk({tag, ".rdy"}, 32'(bus0.hready_out), 32'd1);
    bus0.dmaddr_in = addr; bus0.dmwr_req_in = wr; bus0.dmwr_mask_in = mask;
    bus0.htrans_in = 2'b10;
    @(negedge clk);
    bus0.htrans_in = 2'b00;
  endtask

  // Run a dut0 data phase to completion; stops at the negedge of the
  // completing cycle so a following accept pipelines back-to-back.
  task automatic data0(input string tag, input logic [31:0] wdata, input int exp_w,
                       input bit rd);
    int w = 0;
    logic [31:0] e;
    bus0.dmdata_in = wdata;
    while (!bus0.hready_out && w < 20) begin @(negedge clk); w++; end
    chk({tag, ".waits"}, 32'(w), 32'(exp_w));
    chk({tag, ".hresp"}, 32'(bus0.hresp_out), 32'd0);
    if (rd) begin
      if (sb.size() == 0) chk({tag, ".sb_empty"}, 32'd1, 32'd0);
      else begin e = sb.pop_front(); chk({tag, ".data"}, bus0.data_out, e); end
    end
  endtask

  task automatic wr0(input string tag, input logic [31:0] a, input logic [3:0] m,
                     input logic [31:0] d);
    accept0(tag, a, 1'b1, m);
    data0(tag, d, 1, 1'b0);
  endtask

  task automatic rd0(input string tag, input logic [31:0] a, input logic [31:0] e);
    sb.push_back(e);
    accept0(tag, a, 1'b0, 4'h0);
    data0(tag, 32'h0, 1, 1'b1);
  endtask

  // Out-of-range transfer: ERROR for two cycles, data_out untouched
  task automatic err0(input string tag, input logic [31:0] a, input logic wr,
                      input logic [31:0] d, input logic [31:0] dout);
    accept0(tag, a, wr, 4'hF);
    bus0.dmdata_in = d;
    chk({tag, ".e1_rdy"}, 32'(bus0.hready_out), 32'd0);
    chk({tag, ".e1_resp"}, 32'(bus0.hresp_out), 32'd1);
    @(negedge clk);
    chk({tag, ".e2_rdy"}, 32'(bus0.hready_out), 32'd1);
    chk({tag, ".e2_resp"}, 32'(bus0.hresp_out), 32'd1);
    chk({tag, ".dout"}, bus0.data_out, dout);
  endtask

  initial begin
    bus0.dmaddr_in = '0; bus0.dmwr_req_in = 1'b0; bus0.dmwr_mask_in = '0;
    bus0.dmdata_in = '0; bus0.htrans_in = 2'b00;
    bus1.dmaddr_in = '0; bus1.dmwr_req_in = 1'b0; bus1.dmwr_mask_in = '0;
    bus1.dmdata_in = '0; bus1.htrans_in = 2'b00;
    repeat (2) @(negedge clk);
    chk("rst0.rdy", 32'(bus0.hready_out), 32'd1);
    chk("rst0.resp", 32'(bus0.hresp_out), 32'd0);
    chk("rst0.dout", bus0.data_out, 32'h0);
    chk("rst1.rdy", 32'(bus1.hready_out), 32'd1);
    chk("rst1.dout", bus1.data_out, 32'h0);
    rst = 1'b0;

    // full write then read (read accepted on the commit edge)
    wr0("wr10", 32'h10, 4'hF, 32'hDEADBEEF);
    rd0("rd10", 32'h10, 32'hDEADBEEF);
    // byte-lane write, address bits [1:0] ignored
    wr0("wr12", 32'h12, 4'b0010, 32'h0000AB00);
    rd0("rd10b", 32'h10, 32'hDEADABEF);
    // mask 0 writes nothing
    wr0("wrm0", 32'h10, 4'h0, 32'hFFFFFFFF);
    rd0("rd10c", 32'h10, 32'hDEADABEF);
    // word 0 and the last word
    wr0("wr0", 32'h0, 4'hF, 32'h11223344);
    wr0("wrlast", 32'hFFF, 4'hF, 32'hA5A5A5A5);
    rd0("rdlast", 32'hFFC, 32'hA5A5A5A5);
    rd0("rd0", 32'h0, 32'h11223344);

    // out-of-range read, then write that would alias word 0; a read
    // accepted in ERR2 pipelines straight in
    err0("errrd", 32'h1000, 1'b0, 32'h0, 32'h11223344);
    err0("errwr", 32'h1000, 1'b1, 32'hFFFFFFFF, 32'h11223344);
    rd0("rd0b", 32'h0, 32'h11223344);
    rd0("rd10d", 32'h10, 32'hDEADABEF);

    // reset during the wait cycle of a write
    accept0("rstwr", 32'h10, 1'b1, 4'hF);
    bus0.dmdata_in = 32'hFFFFFFFF;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstwr.rdy", 32'(bus0.hready_out), 32'd1);
    chk("rstwr.resp", 32'(bus0.hresp_out), 32'd0);
    chk("rstwr.dout", bus0.data_out, 32'h0);
    rd0("rd10e", 32'h10, 32'hDEADABEF);

    // BUSY then IDLE with a valid write request never starts a transfer
    bus0.dmaddr_in = 32'h10; bus0.dmwr_req_in = 1'b1; bus0.dmwr_mask_in = 4'hF;
    bus0.dmdata_in = 32'h0; bus0.htrans_in = 2'b01;
    @(negedge clk);
    chk("busy.rdy", 32'(bus0.hready_out), 32'd1);
    chk("busy.resp", 32'(bus0.hresp_out), 32'd0);
    bus0.htrans_in = 2'b00;
    @(negedge clk);
    chk("idle.rdy", 32'(bus0.hready_out), 32'd1);
    @(negedge clk);
    rd0("rd10f", 32'h10, 32'hDEADABEF);

    // zero wait states: write then pipelined read of the same word
    bus1.dmaddr_in = 32'h20; bus1.dmwr_req_in = 1'b1; bus1.dmwr_mask_in = 4'hF;
    bus1.htrans_in = 2'b10;
    @(negedge clk);
    chk("ws0.wr_rdy", 32'(bus1.hready_out), 32'd1);
    bus1.dmdata_in = 32'h12345678;
    bus1.dmwr_req_in = 1'b0;
    sb.push_back(32'h12345678);
    @(negedge clk);
    bus1.htrans_in = 2'b00;
    chk("ws0.rd_rdy", 32'(bus1.hready_out), 32'd1);
    chk("ws0.resp", 32'(bus1.hresp_out), 32'd0);
    if (sb.size() == 0) chk("ws0.sb_empty", 32'd1, 32'd0);
    else chk("ws0.data", bus1.data_out, sb.pop_front());
    @(negedge clk);
    chk("ws0.idle_rdy", 32'(bus1.hready_out), 32'd1);
    chk("sb.drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
